// File: rtl/elevator_dispatcher.sv
// elevator_dispatcher: latches floor calls, picks SCAN direction/target and paces the door for the car FSM
module elevator_dispatcher #(
  parameter int DOOR_CYCLES = 4,
  parameter int CW = $clog2(DOOR_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] call_btn,
  input  logic [5:0] currentF,
  input  logic       isOpen,
  output logic [5:0] requestF,
  output logic [5:0] desF,
  output logic [1:0] up,
  output logic       isClose,
  output logic       fault
);
  typedef enum logic [1:0] {IDLE, HOLD, RUN} state_t;
  localparam logic [CW-1:0] TMAX = CW'(DOOR_CYCLES - 1);
  state_t state, state_next;
  logic [CW-1:0] timer, timer_next, timer_inc;
  logic [5:0] r, below, above, hit_up, hit_dn, des_up, des_dn, des_next;
  logic [1:0] up_next;
  logic onehot, reopen;
  assign onehot = (currentF != 6'd0) && ((currentF & (currentF - 6'd1)) == 6'd0);
  assign r = requestF & ~currentF;
  // below/above masks are only meaningful for a one-hot position; on a fault they are ignored
  assign below = currentF - 6'd1;
  assign above = ~(below | currentF);
  assign hit_up = r & above;
  assign hit_dn = r & below;
  assign des_up = hit_up & (~hit_up + 6'd1);
  assign reopen = |(call_btn & currentF);
  assign timer_inc = (timer == TMAX) ? timer : timer + CW'(1);
  assign isClose = (state == RUN);
  always_comb begin
    des_dn = 6'd0;
    for (int i = 0; i < 6; i++)
      if (hit_dn[i]) des_dn = 6'b1 << i;
  end
  assign up_next = (up == 2'b10 && hit_up != 6'd0) ? 2'b10 :
                   (up == 2'b01 && hit_dn != 6'd0) ? 2'b01 :
                   (hit_up != 6'd0) ? 2'b10 :
                   (hit_dn != 6'd0) ? 2'b01 : 2'b00;
  assign des_next = (up_next == 2'b10) ? des_up : (up_next == 2'b01) ? des_dn : currentF;
  always_comb begin
    state_next = state;
    timer_next = timer;
    if (!onehot) begin
      state_next = HOLD;
      timer_next = '0;
    end else begin
      case (state)
        IDLE: begin
          timer_next = '0;
          if (r != 6'd0) state_next = HOLD;
        end
        HOLD: begin
          if (reopen) timer_next = '0;
          else begin
            timer_next = timer_inc;
            if (timer_inc == TMAX) state_next = (r != 6'd0) ? RUN : IDLE;
          end
        end
        RUN: begin
          if (isOpen) begin
            state_next = HOLD;
            timer_next = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      requestF <= 6'd0;
      desF <= 6'b000001;
      up <= 2'b00;
      state <= IDLE;
      timer <= '0;
      fault <= 1'b0;
    end else begin
      requestF <= (requestF | call_btn) & ~(currentF & {6{isOpen}});
      state <= state_next;
      timer <= timer_next;
      fault <= fault | ~onehot;
      if (onehot) begin
        up <= up_next;
        desF <= des_next;
      end
    end
  end
endmodule

// File: tb/tb_elevator_dispatcher.sv
// tb_elevator_dispatcher: directed SCAN/door-timing scenarios with immediate-assertion checks
module tb_elevator_dispatcher;
  logic clk = 0, reset = 1, isOpen = 1;
  logic [5:0] call_btn = 0, currentF = 6'b000001;
  logic [5:0] requestF, desF;
  logic [1:0] up;
  logic isClose, fault;
  int checks = 0, errors = 0;
  bit seen;
  localparam logic [5:0] F1 = 6'b000001, F2 = 6'b000010, F2M = 6'b000100,
                         F3 = 6'b001000, F3M = 6'b010000, F4 = 6'b100000;
  elevator_dispatcher #(.DOOR_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .call_btn(call_btn), .currentF(currentF), .isOpen(isOpen),
    .requestF(requestF), .desF(desF), .up(up), .isClose(isClose), .fault(fault)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  initial begin
    tick; tick;
    reset = 0;
    chk("rst_req", requestF, 0); chk("rst_des", desF, F1); chk("rst_up", 6'(up), 0);
    chk("rst_close", 6'(isClose), 0); chk("rst_fault", 6'(fault), 0);
    // call F3 from F1
    call_btn = F3; tick; call_btn = 0;
    chk("t1_req", requestF, F3); chk("t1_up_lag", 6'(up), 0);
    tick;
    chk("t1_up", 6'(up), 6'b10); chk("t1_des", desF, F3); chk("t1_close0", 6'(isClose), 0);
    tick; tick;
    chk("t1_close_early", 6'(isClose), 0);
    tick;
    chk("t1_close", 6'(isClose), 1);
    // arrive at F3
    isOpen = 0; currentF = F2; tick;
    chk("t1_run", 6'(isClose), 1);
    currentF = F3; isOpen = 1; tick;
    chk("t2_req", requestF, 0); chk("t2_close", 6'(isClose), 0);
    tick; tick; tick;
    chk("t2_up", 6'(up), 0); chk("t2_des", desF, F3); chk("t2_idle", 6'(isClose), 0);
    // HOLD at F2 with F4 pending, own-floor press reopens
    currentF = F2; call_btn = F4; tick; call_btn = 0;
    chk("t4_req", requestF, F4);
    tick;
    chk("t4_up", 6'(up), 6'b10); chk("t4_des", desF, F4);
    tick; tick;
    call_btn = F2; tick; call_btn = 0;
    chk("t4_reopen", 6'(isClose), 0); chk("t4_req_own", requestF, F4);
    tick; tick;
    chk("t4_close_early", 6'(isClose), 0);
    tick;
    chk("t4_close", 6'(isClose), 1);
    // travel up, F2 called behind the car
    isOpen = 0; currentF = F2M; tick;
    currentF = F3; call_btn = F2; tick; call_btn = 0;
    chk("t3_req", requestF, F4 | F2);
    currentF = F3M; tick; tick;
    chk("t3_up", 6'(up), 6'b10); chk("t3_des", desF, F4);
    currentF = F4; isOpen = 1; tick;
    chk("t3_req_served", requestF, F2); chk("t3_rev_up", 6'(up), 6'b01);
    chk("t3_rev_des", desF, F2); chk("t3_close", 6'(isClose), 0);
    // clear wins over a simultaneous press
    currentF = F2M; call_btn = F2M; tick; call_btn = 0;
    chk("t5_req", requestF, F2);
    chk("t5_up", 6'(up), 6'b01); chk("t5_des", desF, F2);
    // non-one-hot position
    currentF = 6'b000110; tick;
    chk("t6_fault", 6'(fault), 1); chk("t6_close", 6'(isClose), 0);
    chk("t6_up_hold", 6'(up), 6'b01); chk("t6_des_hold", desF, F2);
    currentF = F1; isOpen = 0; call_btn = F4; tick; call_btn = 0;
    chk("t6_sticky", 6'(fault), 1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick;
      seen = isClose;
    end
    chk("t6_reach_run", 6'(seen), 1);
    reset = 1; tick;
    chk("t6_rst_req", requestF, 0); chk("t6_rst_des", desF, F1); chk("t6_rst_up", 6'(up), 0);
    chk("t6_rst_close", 6'(isClose), 0); chk("t6_rst_fault", 6'(fault), 0);
    reset = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
